pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the single-issue core. It replaces the fixed-reset, always-load PC register. The block selects the next fetch address by priority: exception, redirect, stall, sequential. It adds a small circular return-address stack (RAS) for call/return prediction. It sits at the head of the fetch stage, and its `pc` output drives instruction-memory address and downstream PC pipelines.

## Interface
Parameters:
- `WIDTH`, 32, address width in bits (≥ 8).
- `RESET_VECTOR`, 32'h0000_3000, PC value at reset.
- `EXC_VECTOR`, 32'h0000_4180, PC loaded on exception.
- `INC`, 4, sequential increment in bytes.
- `RAS_DEPTH`, 4, return-stack entries, power of two, 2..16.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `stall` in 1: hold PC and RAS this cycle.
- `exc` in 1: take exception; highest priority.
- `redirect` in 1: load `target` (branch/jump/return resolved).
- `target` in WIDTH: redirect address.
- `push` in 1: push `push_addr` onto the RAS (call).
- `push_addr` in WIDTH: return address to push.
- `pop` in 1: pop the RAS (return).
- `pc` out WIDTH: current fetch address (registered).
- `pc_plus` out WIDTH: `pc + INC`, combinational.
- `ras_top` out WIDTH: top-of-stack entry; 0 when empty.
- `ras_empty` out 1: stack count is 0.
- `ras_full` out 1: stack count equals RAS_DEPTH.
- `misalign` out 1: registered misaligned-redirect flag; see Configuration.

## Operation
- The next PC is chosen by priority (first match wins):
  1. `exc` selects EXC_VECTOR.
  2. `redirect` selects `target`.
  3. `stall` keeps `pc`.
  4. Otherwise `pc + INC`.
- `exc` and `redirect` override `stall`.
- Arithmetic is modulo 2^WIDTH. `pc + INC` wraps from all-ones to low addresses silently.
- RAS storage:
  - RAS_DEPTH × WIDTH array, a write pointer `sp`, and a count `cnt` in 0..RAS_DEPTH.
  - `ras_top` is entry `sp-1` when `cnt>0`, otherwise 0.
- RAS operations are enabled only when `exc`=0 and `stall`=0. Otherwise push and pop are ignored.
- Push only:
  - Write `push_addr` at `sp`, then `sp++`.
  - `cnt++`, saturating at RAS_DEPTH.
  - When full, the oldest entry is overwritten (pointer wrap).
- Pop only: if `cnt>0`, then `sp--` and `cnt--`. If empty, the pop is ignored with no underflow.
- Push and pop together:
  - If `cnt>0`, the top entry is replaced with `push_addr`; `sp` and `cnt` are unchanged.
  - If `cnt=0`, this acts as a plain push.
- `exc` clears the RAS: `cnt` goes to 0 and `sp` goes to 0. Array contents are don't-care.
- `redirect` does not affect the RAS. Callers assert `pop` alongside a return redirect.

## Timing
- Reset (`reset`=0, asynchronous) gives:
  - `pc`=RESET_VECTOR, `cnt`=0, `sp`=0, `misalign`=0.
  - Therefore `ras_empty`=1, `ras_full`=0, `ras_top`=0.
- Release is sampled at the next rising edge. The first edge with `reset`=1 loads `RESET_VECTOR+INC`, assuming no other controls are asserted.
- `pc`, `sp`, `cnt` and `misalign` update only on the rising `clk` edge, or on asynchronous reset.
- Next-PC latency is 1 cycle: the value selected in cycle N appears on `pc` in cycle N+1.
- `pc_plus`, `ras_top`, `ras_empty` and `ras_full` are combinational from registered state. They do not depend on the same-cycle `push`/`pop`.
- A return redirect must use `ras_top` sampled in the cycle before `pop`, or in the same cycle, since `ras_top` reflects pre-pop state.
- Reset asserted mid-operation aborts everything immediately. There is no pending update after release.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - A `redirect` whose `target[1:0]`≠0 and is not pre-empted by `exc` is not loaded.
  - The PC instead loads EXC_VECTOR and the RAS is cleared, as for `exc`.
  - `misalign` is 1 for exactly the following cycle, aligned with `pc`=EXC_VECTOR, then returns to 0.
  - Stall has no effect on this check.
- `PC_ALIGN_CHECK_EN` undefined: targets load verbatim and `misalign` is tied to 0.

## Test plan
- Reset and sequential fetch:
  - Stimulus: assert `reset`=0 asynchronously mid-cycle, then release with no controls.
  - Required: `pc`=0x3000 immediately, then 0x3004 and 0x3008 on successive edges. `ras_empty`=1 throughout.
- Priority:
  - Stimulus: one cycle with `stall`=1, `redirect`=1, `target`=0x3100, then one cycle with `exc`=1 and `redirect`=1.
  - Required: `pc`=0x3100, then 0x4180.
- RAS overflow wrap:
  - Stimulus: push 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4).
  - Required: `ras_full`=1 after 4 pushes; `ras_top`=0x50.
  - Then pop 4 times: `ras_top` reads 0x40, 0x30, 0x20, after which `ras_empty`=1. A 5th pop is ignored with `cnt`=0.
- Simultaneous push/pop:
  - Stimulus: with the stack holding [0x10,0x20], assert push 0x99 and pop together.
  - Required: `ras_top`=0x99 and `cnt`=2. The same stimulus on an empty stack gives `ras_top`=0x99 and `cnt`=1.
- Stall gating:
  - Stimulus: `stall`=1 with push 0x77 for 3 cycles.
  - Required: `pc` is held and the RAS is unchanged.
- Misaligned redirect (`PC_ALIGN_CHECK_EN` defined):
  - Stimulus: `redirect` to 0x3102.
  - Required: `pc`=0x4180 and `misalign`=1 for one cycle; the RAS is cleared.
  - With the macro undefined: `pc`=0x3102 and `misalign`=0.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator: priority next-PC select (exc > redirect > stall > seq)
// with a circular return-address stack. Optional macro PC_ALIGN_CHECK_EN traps misaligned redirects.
module pc_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_4180,
    parameter int               INC          = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             exc,
    input  logic             redirect,
    input  logic [WIDTH-1:0] target,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             pop,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             misalign
);

    localparam int               PW      = $clog2(RAS_DEPTH);
    localparam logic [PW:0]      CNT_MAX = (PW+1)'(RAS_DEPTH);
    localparam logic [PW:0]      CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0]    SP_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);

    // Occupancy count saturates at the stack depth; older entries are simply overwritten.
    function automatic logic [PW:0] sat_inc(input logic [PW:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_dec;
    logic [PW-1:0]    sp_next;
    logic [PW:0]      cnt;
    logic [PW:0]      cnt_next;
    logic [WIDTH-1:0] pc_next;
    logic [PW-1:0]    wr_idx;
    logic             wr_en;
    logic             mis_redir;
    logic             trap;
    logic             ras_en;

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    assign mis_redir = redirect && !exc && (target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= mis_redir;
        end
    end

    assign misalign = misalign_q;
`else
    assign mis_redir = 1'b0;
    assign misalign  = 1'b0;
`endif

    assign trap    = exc || mis_redir;
    assign ras_en  = !trap && !stall;
    assign sp_dec  = sp - SP_ONE;
    assign pc_plus = pc + INC_W;

    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == CNT_MAX);
    assign ras_top   = ras_empty ? '0 : ras_mem[sp_dec];

    always_comb begin
        pc_next = pc_plus;
        if (trap) begin
            pc_next = EXC_VECTOR;
        end else if (redirect) begin
            pc_next = target;
        end else if (stall) begin
            pc_next = pc;
        end
    end

    // Push+pop on a non-empty stack rewrites the top in place; on an empty stack it is a plain push.
    always_comb begin
        sp_next  = sp;
        cnt_next = cnt;
        wr_en    = 1'b0;
        wr_idx   = sp;
        if (trap) begin
            sp_next  = '0;
            cnt_next = '0;
        end else if (ras_en) begin
            if (push && pop && !ras_empty) begin
                wr_en  = 1'b1;
                wr_idx = sp_dec;
            end else if (push) begin
                wr_en    = 1'b1;
                sp_next  = sp + SP_ONE;
                cnt_next = sat_inc(cnt);
            end else if (pop && !ras_empty) begin
                sp_next  = sp_dec;
                cnt_next = cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc  <= RESET_VECTOR;
            sp  <= '0;
            cnt <= '0;
        end else begin
            pc  <= pc_next;
            sp  <= sp_next;
            cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ras_mem[wr_idx] <= push_addr;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (default parameters).
// Expectations for the misaligned redirect follow PC_ALIGN_CHECK_EN if defined.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        exc = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic        push = 1'b0;
    logic [31:0] push_addr = '0;
    logic        pop = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic        misalign;

    int checks = 0;
    int failures = 0;
    logic [31:0] held_pc;

    pc_gen dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .exc       (exc),
        .redirect  (redirect),
        .target    (target),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .pc        (pc),
        .pc_plus   (pc_plus),
        .ras_top   (ras_top),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; exc = 0; redirect = 0; push = 0; pop = 0;
    endtask

    task automatic do_push(input logic [31:0] a);
        push = 1; push_addr = a;
        step();
        push = 0;
    endtask

    task automatic do_pop();
        pop = 1;
        step();
        pop = 0;
    endtask

    initial begin
        step();
        step();
        // Asynchronous reset mid-cycle
        #2 reset = 1'b0;
        #1;
        check("rst_pc_async", pc, 32'h3000);
        check("rst_empty", ras_empty, 1);
        check("rst_full", ras_full, 0);
        check("rst_top", ras_top, 0);
        check("rst_misalign", misalign, 0);
        step();
        check("rst_pc_held", pc, 32'h3000);
        reset = 1'b1;
        step();
        check("seq_pc1", pc, 32'h3004);
        check("seq_empty1", ras_empty, 1);
        step();
        check("seq_pc2", pc, 32'h3008);
        check("seq_empty2", ras_empty, 1);
        check("seq_pc_plus", pc_plus, 32'h300C);

        // Priority
        stall = 1; redirect = 1; target = 32'h3100;
        step();
        check("prio_redir_over_stall", pc, 32'h3100);
        stall = 0; exc = 1;
        step();
        check("prio_exc", pc, 32'h4180);
        check("prio_exc_plus", pc_plus, 32'h4184);
        idle();

        // Overflow wrap
        do_push(32'h10);
        do_push(32'h20);
        do_push(32'h30);
        check("ovf_not_full3", ras_full, 0);
        do_push(32'h40);
        check("ovf_full4", ras_full, 1);
        check("ovf_top4", ras_top, 32'h40);
        do_push(32'h50);
        check("ovf_full5", ras_full, 1);
        check("ovf_top5", ras_top, 32'h50);
        do_pop();
        check("pop1_top", ras_top, 32'h40);
        check("pop1_full", ras_full, 0);
        do_pop();
        check("pop2_top", ras_top, 32'h30);
        do_pop();
        check("pop3_top", ras_top, 32'h20);
        do_pop();
        check("pop4_empty", ras_empty, 1);
        check("pop4_top", ras_top, 0);
        do_pop();
        check("pop5_empty", ras_empty, 1);
        check("pop5_top", ras_top, 0);

        // Push+pop on empty acts as push (cnt=1)
        push = 1; pop = 1; push_addr = 32'h99;
        step();
        idle();
        check("pp_empty_top", ras_top, 32'h99);
        check("pp_empty_nonempty", ras_empty, 0);
        do_pop();
        check("pp_empty_cnt1", ras_empty, 1);

        // Push+pop on [0x10,0x20] replaces top
        do_push(32'h10);
        do_push(32'h20);
        check("pp_pre_top", ras_top, 32'h20);
        push = 1; pop = 1; push_addr = 32'h99;
        step();
        idle();
        check("pp_top", ras_top, 32'h99);

        // Stall gating
        held_pc = pc;
        stall = 1; push = 1; push_addr = 32'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, held_pc);
            check("stall_top", ras_top, 32'h99);
        end
        idle();

        // cnt still 2 after the replace
        do_pop();
        check("pp_cnt2_pop1", ras_top, 32'h10);
        check("pp_cnt2_nonempty", ras_empty, 0);
        do_pop();
        check("pp_cnt2_pop2", ras_empty, 1);

        // Exception clears RAS
        do_push(32'h55);
        check("exc_pre_top", ras_top, 32'h55);
        exc = 1; push = 1; push_addr = 32'h12;
        step();
        idle();
        check("exc_clear_empty", ras_empty, 1);
        check("exc_clear_top", ras_top, 0);
        check("exc_clear_pc", pc, 32'h4180);

        // Modulo wrap
        redirect = 1; target = 32'hFFFF_FFFC;
        step();
        idle();
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_plus", pc_plus, 32'h0);
        step();
        check("wrap_pc0", pc, 32'h0);

        // Misaligned redirect
        do_push(32'h66);
        redirect = 1; target = 32'h3102;
        step();
        idle();
`ifdef PC_ALIGN_CHECK_EN
        check("mis_pc", pc, 32'h4180);
        check("mis_flag", misalign, 1);
        check("mis_ras_clear", ras_empty, 1);
        step();
        check("mis_flag_drop", misalign, 0);
        check("mis_pc_next", pc, 32'h4184);
`else
        check("mis_pc", pc, 32'h3102);
        check("mis_flag", misalign, 0);
        check("mis_ras_kept", ras_top, 32'h66);
        step();
        check("mis_pc_next", pc, 32'h3106);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
